uart_fifo_controller: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/rx_module.sv | 99 +++++++++
 rtl/tx_module.sv | 82 ++++++++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_fifo_controller.sv | 135 +++++++++++++
 tb/tb_uart_fifo_controller.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared constants, character-format helpers and feed-FSM encoding for uart_fifo_controller.
package uart_pkg;
   localparam int unsigned MaxUartDataW   = 8;
   localparam int unsigned StopConfWidth  = 2;
   localparam int unsigned DataConfWidth  = 2;
   localparam int unsigned TotalConfWidth = StopConfWidth + DataConfWidth + 1;
   localparam int unsigned RxEntryW       = MaxUartDataW + 2;
   localparam int unsigned FrameW         = 12;

   typedef enum logic [1:0] {
      FEED_IDLE = 2'd0,
      FEED_LOAD = 2'd1,
      FEED_WAIT = 2'd2
   } feed_state_e;

   // conf = {data, stop, parity_en}: data field selects 5..8 bits, non-zero stop field means 2 stop bits
   function automatic logic [3:0] conf_data_bits(input logic [TotalConfWidth-1:0] conf);
      return 4'd5 + {2'b00, conf[TotalConfWidth-1 -: DataConfWidth]};
   endfunction

   function automatic logic conf_two_stop(input logic [TotalConfWidth-1:0] conf);
      return conf[StopConfWidth:1] != 2'b00;
   endfunction

   function automatic logic conf_parity(input logic [TotalConfWidth-1:0] conf);
      return conf[0];
   endfunction

   function automatic logic even_parity(input logic [MaxUartDataW-1:0] d);
      return ^d;
   endfunction

   function automatic logic [MaxUartDataW-1:0] mask_data(input logic [MaxUartDataW-1:0] d,
                                                         input logic [3:0] n);
      logic [MaxUartDataW-1:0] m;
      for (int i = 0; i < MaxUartDataW; i++) m[i] = (4'(i) < n) ? d[i] : 1'b0;
      return m;
   endfunction
endpackage

// File: rtl/rx_module.sv
// UART receive framing engine: mid-bit sampling at 16x, reports data plus parity and stop errors.
module rx_module
   import uart_pkg::*;
#(
   parameter int unsigned SMP_W = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      baud_en_i,
   input  logic                      en_i,
   input  logic [TotalConfWidth-1:0] conf_i,
   input  logic                      rx_i,
   output logic [MaxUartDataW-1:0]   data_o,
   output logic                      parity_err_o,
   output logic                      stop_err_o,
   output logic                      done_o
);
   localparam logic [SMP_W-1:0] MidSmp = {1'b0, {(SMP_W-1){1'b1}}};

   logic                    act_q, act_d, perr_q, perr_d, serr_q, serr_d, done_q, done_d;
   logic [SMP_W-1:0]        smp_q, smp_d;
   logic [3:0]              idx_q, idx_d, nd_s, par_s, nsamp_s;
   logic [15:0]             bits_q, bits_d, nb_s;
   logic [MaxUartDataW-1:0] data_q, data_d;

   assign data_o       = data_q;
   assign parity_err_o = perr_q;
   assign stop_err_o   = serr_q;
   assign done_o       = done_q;

   // Sample 0 checks the start bit is still low; the final sample is the last stop bit
   always_comb begin
      nd_s    = conf_data_bits(conf_i);
      par_s   = {3'b000, conf_parity(conf_i)};
      nsamp_s = nd_s + par_s + (conf_two_stop(conf_i) ? 4'd2 : 4'd1);
      nb_s    = bits_q;
      nb_s[idx_q - 4'd1] = rx_i;
      act_d   = act_q;
      smp_d   = smp_q;
      idx_d   = idx_q;
      bits_d  = bits_q;
      data_d  = data_q;
      perr_d  = perr_q;
      serr_d  = serr_q;
      done_d  = 1'b0;
      if (!act_q) begin
         if (en_i && !rx_i) begin
            act_d = 1'b1;
            smp_d = '0;
            idx_d = 4'd0;
         end else begin
            act_d = 1'b0;
         end
      end else if (baud_en_i) begin
         smp_d = smp_q + SMP_W'(1);
         if (smp_q == MidSmp) begin
            if (idx_q == 4'd0) begin
               act_d = !rx_i;
               idx_d = 4'd1;
            end else if (idx_q == nsamp_s) begin
               act_d  = 1'b0;
               done_d = 1'b1;
               data_d = mask_data(nb_s[MaxUartDataW-1:0], nd_s);
               perr_d = conf_parity(conf_i) & (even_parity(data_d) ^ nb_s[nd_s]);
               serr_d = ~nb_s[nd_s + par_s] | (conf_two_stop(conf_i) & ~nb_s[nd_s + par_s + 4'd1]);
            end else begin
               bits_d = nb_s;
               idx_d  = idx_q + 4'd1;
            end
         end else begin
            idx_d = idx_q;
         end
      end else begin
         smp_d = smp_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         act_q  <= 1'b0;
         smp_q  <= '0;
         idx_q  <= 4'd0;
         bits_q <= '0;
         data_q <= '0;
         perr_q <= 1'b0;
         serr_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         act_q  <= act_d;
         smp_q  <= smp_d;
         idx_q  <= idx_d;
         bits_q <= bits_d;
         data_q <= data_d;
         perr_q <= perr_d;
         serr_q <= serr_d;
         done_q <= done_d;
      end
   end
endmodule

// File: rtl/tx_module.sv
// UART transmit framing engine: start, 5-8 data bits LSB first, optional even parity, 1-2 stop bits.
module tx_module
   import uart_pkg::*;
#(
   parameter int unsigned SMP_W = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      baud_en_i,
   input  logic [TotalConfWidth-1:0] conf_i,
   input  logic [MaxUartDataW-1:0]   data_i,
   input  logic                      start_i,
   output logic                      tx_o,
   output logic                      done_o
);
   logic              busy_q, busy_d, tx_q, tx_d, done_q, done_d;
   logic [FrameW-1:0] frame_q, frame_d, frame_s;
   logic [3:0]        bits_q, bits_d, nd_s, nbits_s;
   logic [SMP_W-1:0]  smp_q, smp_d;

   assign tx_o   = tx_q;
   assign done_o = done_q;

   // Frame image shifted out LSB first; unused upper positions stay 1 and act as stop bits
   always_comb begin
      nd_s    = conf_data_bits(conf_i);
      nbits_s = 4'd1 + nd_s + {3'b000, conf_parity(conf_i)} + (conf_two_stop(conf_i) ? 4'd2 : 4'd1);
      frame_s = '1;
      frame_s[0] = 1'b0;
      for (int i = 0; i < MaxUartDataW; i++) frame_s[i+1] = (4'(i) < nd_s) ? data_i[i] : 1'b1;
      frame_s[nd_s + 4'd1] = conf_parity(conf_i) ? even_parity(mask_data(data_i, nd_s)) : 1'b1;
   end

   always_comb begin
      busy_d  = busy_q;
      frame_d = frame_q;
      bits_d  = bits_q;
      smp_d   = smp_q;
      done_d  = 1'b0;
      if (!busy_q) begin
         if (start_i) begin
            busy_d  = 1'b1;
            frame_d = frame_s;
            bits_d  = nbits_s;
            smp_d   = '0;
         end else begin
            busy_d = 1'b0;
         end
      end else if (baud_en_i) begin
         if (smp_q == '1) begin
            smp_d   = '0;
            frame_d = {1'b1, frame_q[FrameW-1:1]};
            bits_d  = bits_q - 4'd1;
            busy_d  = (bits_q != 4'd1);
            done_d  = (bits_q == 4'd1);
         end else begin
            smp_d = smp_q + SMP_W'(1);
         end
      end else begin
         smp_d = smp_q;
      end
      tx_d = busy_d ? frame_d[0] : 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q  <= 1'b0;
         frame_q <= '1;
         bits_q  <= 4'd0;
         smp_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         frame_q <= frame_d;
         bits_q  <= bits_d;
         smp_q   <= smp_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered occupancy level.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LvlW-1:0]  level_q, level_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o  = (level_q == LvlW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   // A push into a full FIFO only lands when a pop frees the slot in the same cycle
   always_comb begin
      pop_ok_s  = pop_i && !empty_o;
      push_ok_s = push_i && (!full_o || pop_ok_s);
      wptr_d    = push_ok_s ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d    = pop_ok_s ? rptr_q + PtrW'(1) : rptr_q;
      level_d   = level_q + LvlW'(push_ok_s) - LvlW'(pop_ok_s);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_s) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/uart_fifo_controller.sv
// Buffered UART: programmable 16x baud tick, rx synchroniser, Tx/Rx FWFT FIFOs around the framing engines.
module uart_fifo_controller
   import uart_pkg::*;
#(
   parameter int unsigned MAX_UART_DATA_W    = 8,
   parameter int unsigned STOP_CONF_WIDTH    = 2,
   parameter int unsigned DATA_CONF_WIDTH    = 2,
   parameter int unsigned SAMPLE_COUNT_WIDTH = 4,
   parameter int unsigned BAUD_DIV_W         = 16,
   parameter int unsigned TX_FIFO_DEPTH      = 16,
   parameter int unsigned RX_FIFO_DEPTH      = 16,
   parameter int unsigned SYNC_STAGES        = 3
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [BAUD_DIV_W-1:0]                    baud_div_i,
   input  logic                                     tx_en_i,
   input  logic [STOP_CONF_WIDTH+DATA_CONF_WIDTH:0] tx_conf_i,
   input  logic [MAX_UART_DATA_W-1:0]               tx_data_i,
   input  logic                                     tx_valid_i,
   output logic                                     tx_ready_o,
   output logic [$clog2(TX_FIFO_DEPTH+1)-1:0]       tx_level_o,
   output logic                                     tx_busy_o,
   output logic                                     uart_tx_o,
   input  logic                                     rx_en_i,
   input  logic [STOP_CONF_WIDTH+DATA_CONF_WIDTH:0] rx_conf_i,
   input  logic                                     uart_rx_i,
   output logic [MAX_UART_DATA_W-1:0]               rx_data_o,
   output logic                                     rx_parity_err_o,
   output logic                                     rx_stop_err_o,
   output logic                                     rx_valid_o,
   input  logic                                     rx_ready_i,
   output logic [$clog2(RX_FIFO_DEPTH+1)-1:0]       rx_level_o,
   output logic                                     rx_overflow_o,
   input  logic                                     rx_ovf_clr_i
);
   logic                       rst_s, baud_en_q, baud_en_d, ovf_q, ovf_d;
   logic [BAUD_DIV_W-1:0]      cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0]     sync_q;
   feed_state_e                feed_q, feed_d;
   logic [MAX_UART_DATA_W-1:0] hold_q, hold_d, tx_head_s, rx_data_s;
   logic                       start_q, start_d, tx_done_s, tx_full_s, tx_empty_s;
   logic                       rx_done_s, rx_perr_s, rx_serr_s, rx_full_s, rx_empty_s, rx_pop_s;
   logic [RxEntryW-1:0]        rx_head_s;

   assign rst_s           = ~rst_ni;
   assign tx_ready_o      = ~tx_full_s;
   assign tx_busy_o       = ~tx_empty_s | (feed_q != FEED_IDLE);
   assign rx_valid_o      = ~rx_empty_s;
   assign rx_pop_s        = rx_valid_o & rx_ready_i;
   assign rx_data_o       = rx_valid_o ? rx_head_s[MAX_UART_DATA_W-1:0] : '0;
   assign rx_parity_err_o = rx_valid_o & rx_head_s[MAX_UART_DATA_W];
   assign rx_stop_err_o   = rx_valid_o & rx_head_s[MAX_UART_DATA_W+1];
   assign rx_overflow_o   = ovf_q;

   // >= compare lets a divisor shrunk below the running count tick at once instead of wrapping
   always_comb begin
      if (cnt_q >= baud_div_i) begin
         cnt_d     = '0;
         baud_en_d = 1'b1;
      end else begin
         cnt_d     = cnt_q + BAUD_DIV_W'(1);
         baud_en_d = 1'b0;
      end
      if (rx_done_s && rx_full_s && !rx_pop_s) ovf_d = 1'b1;
      else if (rx_ovf_clr_i)                   ovf_d = 1'b0;
      else                                     ovf_d = ovf_q;
   end

   always_comb begin
      feed_d  = feed_q;
      hold_d  = hold_q;
      start_d = 1'b0;
      case (feed_q)
         FEED_IDLE: begin
            if (tx_en_i && !tx_empty_s) begin
               feed_d  = FEED_LOAD;
               hold_d  = tx_head_s;
               start_d = 1'b1;
            end else begin
               feed_d = FEED_IDLE;
            end
         end
         FEED_LOAD: feed_d = FEED_WAIT;
         FEED_WAIT: begin
            if (tx_done_s) feed_d = FEED_IDLE;
            else           feed_d = FEED_WAIT;
         end
         default: feed_d = FEED_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         baud_en_q <= 1'b0;
         sync_q    <= '1;
         ovf_q     <= 1'b0;
         feed_q    <= FEED_IDLE;
         hold_q    <= '0;
         start_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         baud_en_q <= baud_en_d;
         sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
         ovf_q     <= ovf_d;
         feed_q    <= feed_d;
         hold_q    <= hold_d;
         start_q   <= start_d;
      end
   end

   uart_sync_fifo #(.WIDTH(MAX_UART_DATA_W), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
      .clk_i(clk_i), .rst_i(rst_s), .push_i(tx_valid_i & ~tx_full_s), .pop_i(feed_q == FEED_LOAD),
      .wdata_i(tx_data_i), .rdata_o(tx_head_s), .full_o(tx_full_s), .empty_o(tx_empty_s),
      .level_o(tx_level_o)
   );

   uart_sync_fifo #(.WIDTH(MAX_UART_DATA_W+2), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
      .clk_i(clk_i), .rst_i(rst_s), .push_i(rx_done_s), .pop_i(rx_pop_s),
      .wdata_i({rx_serr_s, rx_perr_s, rx_data_s}), .rdata_o(rx_head_s), .full_o(rx_full_s),
      .empty_o(rx_empty_s), .level_o(rx_level_o)
   );

   tx_module #(.SMP_W(SAMPLE_COUNT_WIDTH)) u_tx (
      .clk_i(clk_i), .rst_i(rst_s), .baud_en_i(baud_en_q), .conf_i(tx_conf_i), .data_i(hold_q),
      .start_i(start_q), .tx_o(uart_tx_o), .done_o(tx_done_s)
   );

   rx_module #(.SMP_W(SAMPLE_COUNT_WIDTH)) u_rx (
      .clk_i(clk_i), .rst_i(rst_s), .baud_en_i(baud_en_q), .en_i(rx_en_i), .conf_i(rx_conf_i),
      .rx_i(sync_q[SYNC_STAGES-1]), .data_o(rx_data_s), .parity_err_o(rx_perr_s),
      .stop_err_o(rx_serr_s), .done_o(rx_done_s)
   );
endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller with the serial output looped back into the receiver.
module tb_uart_fifo_controller;
   localparam logic [4:0] Conf8N1 = 5'b11000;
   localparam logic [4:0] Conf8E1 = 5'b11001;

   logic        clk = 1'b0;
   logic        rst_ni, tx_en, tx_valid, tx_ready, tx_busy, uart_tx;
   logic        rx_en, rx_perr, rx_serr, rx_valid, rx_ready, rx_ovf, rx_clr;
   logic [15:0] baud_div;
   logic [4:0]  tx_conf, rx_conf, tx_level;
   logic [7:0]  tx_data, rx_data, d;
   logic [2:0]  rx_level;
   logic        pb;
   int          total = 0, bad = 0, busy_drops = 0, n;
   bit          mon_busy = 1'b0;
   logic [7:0]  burst_vals [3] = '{8'h55, 8'hA3, 8'h0F};
   logic [7:0]  ovf_vals [5]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   always #5 clk = ~clk;

   uart_fifo_controller #(.RX_FIFO_DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .baud_div_i(baud_div), .tx_en_i(tx_en), .tx_conf_i(tx_conf),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_level_o(tx_level),
      .tx_busy_o(tx_busy), .uart_tx_o(uart_tx), .rx_en_i(rx_en), .rx_conf_i(rx_conf),
      .uart_rx_i(uart_tx), .rx_data_o(rx_data), .rx_parity_err_o(rx_perr), .rx_stop_err_o(rx_serr),
      .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_level_o(rx_level),
      .rx_overflow_o(rx_ovf), .rx_ovf_clr_i(rx_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tk(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (mon_busy && tx_busy !== 1'b1) busy_drops++;
      end
   endtask

   // One frame at baud_div=0: 16 clocks per bit, sampled mid-bit
   task automatic decode(input bit par, output logic [7:0] data, output logic pbit);
      int w = 0;
      data = 8'h00;
      pbit = 1'b0;
      while (uart_tx === 1'b1 && w < 1000) begin tk(1); w++; end
      chk("start_edge", {31'd0, uart_tx}, 32'd0);
      tk(8);
      chk("start_mid", {31'd0, uart_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin tk(16); data[i] = uart_tx; end
      if (par) begin tk(16); pbit = uart_tx; end
      tk(16);
      chk("stop_bit", {31'd0, uart_tx}, 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; baud_div = 16'd3; tx_en = 1'b0; tx_conf = Conf8N1; tx_data = 8'h00;
      tx_valid = 1'b0; rx_en = 1'b0; rx_conf = Conf8N1; rx_ready = 1'b0; rx_clr = 1'b0;
      tk(3);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_tx_level", tx_level, 0);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_level", rx_level, 0);
      chk("rst_rx_ovf", rx_ovf, 0);
      chk("rst_rx_data", {rx_serr, rx_perr, rx_data}, 0);
      rst_ni = 1'b1;

      // baud tick: divisor 3 -> period 4, then drop to 0 with cnt=2
      n = 0;
      while (dut.baud_en_q !== 1'b1 && n < 8) begin tk(1); n++; end
      chk("baud_first", dut.baud_en_q, 1);
      tk(1); chk("baud_gap1", dut.baud_en_q, 0);
      tk(1); chk("baud_gap2", dut.baud_en_q, 0);
      tk(1); chk("baud_gap3", dut.baud_en_q, 0);
      tk(1); chk("baud_period4", dut.baud_en_q, 1);
      tk(2); chk("baud_cnt2", dut.cnt_q, 2);
      baud_div = 16'd0;
      tk(1); chk("baud_div0_next", dut.baud_en_q, 1);
      tk(1); chk("baud_div0_a", dut.baud_en_q, 1);
      tk(1); chk("baud_div0_b", dut.baud_en_q, 1);

      // Tx burst, 8N1, queued while tx_en is low
      for (int i = 0; i < 3; i++) begin tx_valid = 1'b1; tx_data = burst_vals[i]; tk(1); end
      tx_valid = 1'b0;
      chk("burst_level3", tx_level, 3);
      chk("burst_busy", tx_busy, 1);
      chk("burst_line_idle", uart_tx, 1);
      tx_en = 1'b1; mon_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin decode(1'b0, d, pb); chk("burst_frame", d, burst_vals[i]); end
      mon_busy = 1'b0;
      chk("burst_busy_drops", busy_drops, 0);
      tk(12);
      chk("burst_busy_end", tx_busy, 0);
      chk("burst_level_end", tx_level, 0);

      // loopback 8E1 with 0xC4 (three ones -> parity bit 1)
      tx_conf = Conf8E1; rx_conf = Conf8E1; rx_en = 1'b1;
      tx_valid = 1'b1; tx_data = 8'hC4; tk(1); tx_valid = 1'b0;
      decode(1'b1, d, pb);
      chk("loop_line_data", d, 8'hC4);
      chk("loop_line_parity", pb, 1);
      n = 0;
      while (rx_valid !== 1'b1 && n < 100) begin tk(1); n++; end
      chk("loop_rx_valid", rx_valid, 1);
      chk("loop_rx_data", rx_data, 8'hC4);
      chk("loop_rx_perr", rx_perr, 0);
      chk("loop_rx_serr", rx_serr, 0);
      chk("loop_rx_level", rx_level, 1);
      rx_ready = 1'b1; tk(1); rx_ready = 1'b0;
      chk("loop_pop_level", rx_level, 0);
      chk("loop_pop_valid", rx_valid, 0);
      n = 0;
      while (tx_busy !== 1'b0 && n < 100) begin tk(1); n++; end

      // Rx overflow: five characters into a four-deep FIFO
      tx_conf = Conf8N1; rx_conf = Conf8N1;
      for (int i = 0; i < 5; i++) begin tx_valid = 1'b1; tx_data = ovf_vals[i]; tk(1); end
      tx_valid = 1'b0;
      n = 0;
      while (tx_busy !== 1'b0 && n < 2000) begin tk(1); n++; end
      chk("ovf_tx_drained", tx_busy, 0);
      tk(10);
      chk("ovf_level4", rx_level, 4);
      chk("ovf_flag", rx_ovf, 1);
      chk("ovf_head", rx_data, 8'h11);
      rx_clr = 1'b1; tk(1); rx_clr = 1'b0;
      chk("ovf_cleared", rx_ovf, 0);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_order", rx_data, ovf_vals[i]);
         rx_ready = 1'b1; tk(1); rx_ready = 1'b0;
      end
      chk("ovf_empty", rx_level, 0);

      // Full Tx FIFO: 18 writes with tx_en low, only 16 accepted
      rx_en = 1'b0; tx_en = 1'b0;
      for (int i = 0; i < 18; i++) begin tx_valid = 1'b1; tx_data = 8'(8'h30 + i); tk(1); end
      tx_valid = 1'b0;
      chk("full_ready", tx_ready, 0);
      chk("full_level", tx_level, 16);
      tx_en = 1'b1;
      for (int i = 0; i < 16; i++) begin decode(1'b0, d, pb); chk("full_frame", d, 8'(8'h30 + i)); end
      tk(12);
      chk("full_busy_end", tx_busy, 0);
      chk("full_level_end", tx_level, 0);
      chk("full_ready_end", tx_ready, 1);

      // reset during the data bits of the second frame
      rx_en = 1'b1;
      tx_valid = 1'b1; tx_data = 8'hA5; tk(1);
      tx_data = 8'hF0; tk(1);
      tx_data = 8'h0F; tk(1);
      tx_valid = 1'b0;
      decode(1'b0, d, pb);
      chk("mid_first_frame", d, 8'hA5);
      n = 0;
      while (uart_tx === 1'b1 && n < 100) begin tk(1); n++; end
      tk(32);
      chk("mid_line_low", uart_tx, 0);
      chk("mid_tx_level", tx_level, 1);
      chk("mid_rx_level", rx_level, 1);
      rst_ni = 1'b0; tk(1);
      chk("mid_rst_line", uart_tx, 1);
      chk("mid_rst_tx_level", tx_level, 0);
      chk("mid_rst_rx_level", rx_level, 0);
      chk("mid_rst_rx_valid", rx_valid, 0);
      chk("mid_rst_busy", tx_busy, 0);
      rst_ni = 1'b1;
      tk(300);
      chk("post_rst_no_rx", rx_valid, 0);
      chk("post_rst_rx_level", rx_level, 0);
      chk("post_rst_line", uart_tx, 1);
      chk("post_rst_ovf", rx_ovf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
